// File: rtl/fused_pack_pkg.sv
// fused_pack_pkg: shared defaults and lane helpers for the fused-layer width packer
package fused_pack_pkg;
    localparam int IN_W_DEF  = 32;
    localparam int LANES_DEF = 4;

    function automatic int cnt_w(input int lanes);
        return (lanes > 2) ? $clog2(lanes) : 1;
    endfunction

    function automatic int map_lane(input int k, input int lanes, input bit lsb_first);
        return lsb_first ? k : lanes - 1 - k;
    endfunction
endpackage

// File: rtl/fused_width_packer.sv
// fused_width_packer: packs LANES narrow beats into one wide word behind a single
// valid/ready output register, with early close via in_last and a per-lane keep mask
module fused_width_packer
    import fused_pack_pkg::*;
#(
    parameter int IN_W      = IN_W_DEF,
    parameter int LANES     = LANES_DEF,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [IN_W-1:0]       in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [IN_W*LANES-1:0] out_data,
    output logic [LANES-1:0]      out_keep,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready
);
    localparam int OUT_W = IN_W * LANES;
    localparam int CW    = cnt_w(LANES);

    logic [CW-1:0]    lane_cnt;
    logic [OUT_W-1:0] acc_data;
    logic [OUT_W-1:0] merged_data;
    logic [LANES-1:0] acc_keep;
    logic [LANES-1:0] merged_keep;
    logic             closing_possible;
    logic             accept;
    logic             closing;

    // Only a closing beat needs the output register, so only it can be stalled.
    always_comb begin
        closing_possible = (lane_cnt == CW'(LANES - 1)) | in_last;
        in_ready         = ~closing_possible | ~out_valid | out_ready;
        accept           = in_valid & in_ready;
        closing          = accept & closing_possible;
    end

    always_comb begin
        merged_data = acc_data;
        merged_keep = acc_keep;
        for (int i = 0; i < LANES; i++)
            if (i == map_lane(int'(lane_cnt), LANES, LSB_FIRST)) begin
                merged_data[i*IN_W +: IN_W] = in_data;
                merged_keep[i]              = 1'b1;
            end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_cnt <= '0;
            acc_data <= '0;
            acc_keep <= '0;
        end else if (accept) begin
            lane_cnt <= closing ? '0 : lane_cnt + CW'(1);
            acc_data <= closing ? '0 : merged_data;
            acc_keep <= closing ? '0 : merged_keep;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else if (closing) begin
            out_data  <= merged_data;
            out_keep  <= merged_keep;
            out_last  <= in_last;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fused_width_packer.sv
// tb_fused_width_packer: directed vectors plus a randomized scoreboard run for the width packer
module tb_fused_width_packer;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic [127:0] out_data;
    logic [3:0]   out_keep;
    logic         out_last;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         m_in_ready;
    logic [127:0] m_out_data;
    logic [3:0]   m_out_keep;
    logic         m_out_last;
    logic         m_out_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fused_width_packer #(.IN_W(32), .LANES(4), .LSB_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    fused_width_packer #(.IN_W(32), .LANES(4), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(m_in_ready), .out_data(m_out_data), .out_keep(m_out_keep), .out_last(m_out_last),
        .out_valid(m_out_valid), .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic beat(input logic [31:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        #1 check("beat_ready", in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [127:0] mdata, mout_data;
    logic [3:0]   mkeep, mout_keep;
    logic         mout_last, mvalid, exp_rdy, cp, closing;
    int           mcnt, words;

    initial begin
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_keep", out_keep, 0);
        check("rst_last", out_last, 0);
        check("rst_ready", in_ready, 1);
        @(posedge clk);
        #1 reset = 1'b0;

        // 1: full word, LSB first
        beat(32'h11, 0); beat(32'h22, 0); beat(32'h33, 0);
        check("t1_no_early", out_valid, 0);
        beat(32'h44, 0);
        in_valid = 1'b0;
        check("t1_valid", out_valid, 1);
        check("t1_data", out_data, 128'h00000044_00000033_00000022_00000011);
        check("t1_keep", out_keep, 4'hF);
        check("t1_last", out_last, 0);
        check("t1_msb_data", m_out_data, 128'h00000011_00000022_00000033_00000044);
        idle();
        check("t1_one_cycle", out_valid, 0);

        // 2: early close, then next word starts at lane 0
        beat(32'hA, 0); beat(32'hB, 1);
        in_valid = 1'b0;
        check("t2_data", out_data, 128'h0000000B_0000000A);
        check("t2_keep", out_keep, 4'b0011);
        check("t2_last", out_last, 1);
        beat(32'h55, 1);
        in_valid = 1'b0;
        check("t2_next_data", out_data, 128'h55);
        check("t2_next_keep", out_keep, 4'b0001);
        idle();

        // 3: stall with one word pending
        out_ready = 1'b0;
        beat(32'h1, 0); beat(32'h2, 0); beat(32'h3, 0); beat(32'h4, 0);
        beat(32'h5, 0); beat(32'h6, 0); beat(32'h7, 0);
        in_valid = 1'b1; in_data = 32'h8; in_last = 1'b0;
        #1 check("t3_stall_ready", in_ready, 0);
        @(posedge clk);
        #1 check("t3_hold_data", out_data, 128'h00000004_00000003_00000002_00000001);
        check("t3_hold_valid", out_valid, 1);
        out_ready = 1'b1;
        #1 check("t3_release_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("t3_w2_valid", out_valid, 1);
        check("t3_w2_data", out_data, 128'h00000008_00000007_00000006_00000005);
        idle();
        check("t3_drained", out_valid, 0);

        // 4: MSB-first instance
        beat(32'h1, 0); beat(32'h2, 0); beat(32'h3, 0); beat(32'h4, 0);
        in_valid = 1'b0;
        check("t4_msb_data", m_out_data, 128'h00000001_00000002_00000003_00000004);
        check("t4_msb_keep", m_out_keep, 4'hF);
        beat(32'h5, 1);
        in_valid = 1'b0;
        check("t4_msb_single_keep", m_out_keep, 4'b1000);
        check("t4_msb_single_data", m_out_data, 128'h00000005_00000000_00000000_00000000);
        check("t4_lsb_single_keep", out_keep, 4'b0001);
        idle();

        // 5: reset mid-word with a stalled word pending
        out_ready = 1'b0;
        beat(32'hC1, 0); beat(32'hC2, 0); beat(32'hC3, 0); beat(32'hC4, 0);
        beat(32'hD1, 0); beat(32'hD2, 0);
        in_valid = 1'b0;
        reset = 1'b1;
        #1 check("t5_valid", out_valid, 0);
        check("t5_data", out_data, 0);
        check("t5_keep", out_keep, 0);
        check("t5_last", out_last, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        beat(32'h7, 0); beat(32'h8, 0); beat(32'h9, 0); beat(32'hA, 0);
        in_valid = 1'b0;
        check("t5_keep_full", out_keep, 4'hF);
        check("t5_lane0", out_data[31:0], 32'h7);
        check("t5_data_full", out_data, 128'h0000000A_00000009_00000008_00000007);
        idle();

        // 6: random traffic against a reference model
        reset = 1'b1;
        #1 reset = 1'b0;
        mdata = '0; mkeep = '0; mcnt = 0;
        mout_data = '0; mout_keep = '0; mout_last = 1'b0; mvalid = 1'b0; words = 0;
        for (int n = 0; n < 10000; n++) begin
            check("r_valid", out_valid, mvalid);
            if (mvalid) begin
                check("r_data", out_data, mout_data);
                check("r_keep", out_keep, mout_keep);
                check("r_last", out_last, mout_last);
            end
            in_valid  = ($urandom_range(9) < 7);
            in_last   = ($urandom_range(4) == 0);
            out_ready = ($urandom_range(9) < 6);
            in_data   = $urandom;
            cp      = (mcnt == 3) || in_last;
            exp_rdy = !cp || !mvalid || out_ready;
            #1 check("r_ready", in_ready, exp_rdy);
            closing = in_valid && exp_rdy && cp;
            if (mvalid && out_ready) words++;
            if (in_valid && exp_rdy) begin
                mdata[mcnt*32 +: 32] = in_data;
                mkeep[mcnt] = 1'b1;
                mcnt++;
            end
            if (closing) begin
                mout_data = mdata;
                mout_keep = mkeep;
                mout_last = in_last;
                mvalid    = 1'b1;
                mdata = '0; mkeep = '0; mcnt = 0;
            end else if (out_ready) begin
                mvalid = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (words < 1000) begin
            errors++;
            $display("FAIL r_words got %0d exp >= 1000", words);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fused_width_packer.md
# fused_width_packer

Parametrised serial-to-parallel packer for the fused-layer datapath. It collects LANES narrow beats of IN_W bits into one LANES*IN_W-bit word and presents that word on a valid/ready output with backpressure. It supports early word termination via in_last, with a per-lane keep mask. It sits between the per-cycle PE/BRAM read stream and the wide fused-buffer write port.

## Interface
- IN_W, 32: input beat width in bits (≥1).
- LANES, 4: beats per output word (≥2). OUT_W = IN_W*LANES.
- LSB_FIRST, 1: if 1, beat k lands in bits [k*IN_W +: IN_W]. If 0, beat k lands in lane LANES-1-k.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  IN_W  input beat.
- in_valid  in  1  beat offered.
- in_last  in  1  beat closes the current word early; qualified by in_valid.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- out_data  out  OUT_W  packed word.
- out_keep  out  LANES  bit i = lane i holds a real beat (physical lane index, after the LSB_FIRST mapping).
- out_last  out  1  word was closed by in_last.
- out_valid  out  1  word available.
- out_ready  in  1  word consumed when out_valid & out_ready.

## Operation
- Internal state:
  - lane_cnt, width clog2(LANES), counts 0..LANES-1.
  - acc_data, OUT_W bits.
  - acc_keep, LANES bits.
  - Output register: out_data, out_keep, out_last, out_valid.
- Accept, with lane_cnt = k:
  - Write in_data into lane k (or LANES-1-k when LSB_FIRST=0).
  - Set the matching keep bit.
- Word closes when the accepted beat has k == LANES-1, or in_last = 1, or both.
- On close:
  - Output register loads acc_data merged with the current beat.
  - out_keep loads the merged keep mask; out_last = in_last.
  - out_valid is set.
  - acc_data and acc_keep clear to 0; lane_cnt returns to 0.
- Lanes not written before an early close read as 0 in out_data.
- No close: lane_cnt increments and the output register is untouched.
- in_ready = ~closing_possible | ~out_valid | out_ready, where closing_possible = (lane_cnt == LANES-1) | in_last.
  - Non-closing beats are always accepted, even while the output is stalled.
- Output register clears out_valid on consume, unless a close happens in the same cycle. In that case the register reloads and out_valid stays 1.
- in_last on the first beat (k = 0) emits a one-lane word: keep = lane-0 mapping only.
- lane_cnt wraps LANES-1 → 0 only through a close; no other wrap path exists.
- in_data, in_last and out_* are ignored or held when their valid is low.
- Reset mid-word discards the partial word and any pending output.

## Timing
- Reset values: out_valid 0, out_data 0, out_keep 0, out_last 0, lane_cnt 0, acc 0.
  - in_ready is 1 out of reset, since out_valid = 0.
- Latency: the word appears with out_valid = 1 in the cycle after its closing beat is accepted.
- Throughput: one beat per cycle sustained with out_ready held 1; no bubbles between words.
- Stall behaviour while out_valid = 1 and out_ready = 0:
  - out_data, out_keep and out_last are stable.
  - in_ready drops only when the next beat would close.
- in_ready depends combinationally on out_ready, in_last and in_valid-independent state. It does not depend on in_valid.
- Backpressure is a single register stage; no skid buffer beyond the output register.

## Structure
- Package fused_pack_pkg holds:
  - The function clog2-style lane-count width.
  - The lane-index mapping function map_lane(k, LSB_FIRST).
  - The default parameters IN_W = 32, LANES = 4.
- Single module; no sub-module needed.
- The output register and the accumulator live in separate always_ff blocks, both sensitive to posedge clk / posedge reset.

## Test plan
1. IN_W = 32, LANES = 4, out_ready = 1; beats 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
   - Required: one cycle after beat 4, out_data = 0x00000044_00000033_00000022_00000011, keep 4'hF, last 0, out_valid for exactly one cycle.
2. Beats 0xA, 0xB with in_last on 0xB.
   - Required: out_data = 0x0..0_0000000B_0000000A, keep 4'b0011, out_last 1, next word starts at lane 0.
3. out_ready = 0 with word 1 pending; send 3 more beats, then a 4th.
   - Required: the first 3 are accepted; in_ready = 0 on the 4th.
   - Raise out_ready: word 1 is consumed and the 4th is accepted the same cycle; word 2 is valid on the next cycle with no gap.
4. LSB_FIRST = 0 with beats 1, 2, 3, 4.
   - Required: out_data = 0x00000001_00000002_00000003_00000004.
   - Single beat 5 with in_last: keep 4'b1000, data 0x00000005_0..0.
5. Assert reset after 2 beats and a pending stalled word.
   - Required: out_valid = 0 and all outputs 0 immediately.
   - Beats 7, 8, 9, 10 then produce keep 4'hF with lane 0 = 7.
6. Random 10k beats with random in_last, in_valid and out_ready; scoreboard against a reference model.
   - Required: no loss or duplication, and keep/last match the model.
